// File: rtl/lift_pkg.sv
// Shared types and constants for the elevator car controller slice.
// Used by the request front end, the car controller and later stages.
package lift_pkg;

  localparam int NUM_FLOORS = 11;
  localparam int FLOOR_W    = 4;

  localparam logic [1:0] MOTOR_IDLE = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b11;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } call_state_t;

  // A retire at this floor outranks a fresh press on the same edge.
  function automatic call_state_t call_next(
    call_state_t s,
    logic        acc,
    logic        srv
  );
    case (s)
      IDLE:    call_next = (acc && !srv) ? PENDING : IDLE;
      PENDING: call_next = srv ? IDLE : PENDING;
      default: call_next = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/call_request_unit_if.sv
// Button, car-status and request/lamp bundle between the
// push-button front end and the car controller.
interface call_request_unit_if;
  import lift_pkg::*;

  logic [NUM_FLOORS-1:0] hall_btn;
  logic [NUM_FLOORS-1:0] cab_btn;
  logic [FLOOR_W-1:0]    lift_floor;
  logic [1:0]            motor_signal;
  logic [NUM_FLOORS-1:0] floor_req;
  logic [NUM_FLOORS-1:0] req_in_lift;
  logic [NUM_FLOORS-1:0] hall_lamp;
  logic [NUM_FLOORS-1:0] cab_lamp;

  modport master (
    output hall_btn, cab_btn,
    output lift_floor, motor_signal,
    input  floor_req, req_in_lift,
    input  hall_lamp, cab_lamp
  );

  modport slave (
    input  hall_btn, cab_btn,
    input  lift_floor, motor_signal,
    output floor_req, req_in_lift,
    output hall_lamp, cab_lamp
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer and saturating debounce
// counter with a single-cycle accept per continuous hold.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic accept
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] CNT_HIT = 4'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
      cnt  <= 4'd0;
    end else begin
      sync <= {sync[0], btn};
      if (!sync[1])
        cnt <= 4'd0;
      else if (cnt < CNT_MAX)
        cnt <= cnt + 4'd1;
    end
  end

  // Saturation at CNT_MAX keeps this single-shot until a low cycle.
  assign accept = sync[1] && (cnt == CNT_HIT);

endmodule

// File: rtl/call_request_unit.sv
// Hall/cab call front end: debounced presses become pending calls
// with lamps and one-cycle request pulses to the car controller.
module call_request_unit
  import lift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  call_request_unit_if.slave bus
);

  logic [NUM_FLOORS-1:0] hall_acc;
  logic [NUM_FLOORS-1:0] cab_acc;
  logic [NUM_FLOORS-1:0] served;
  logic [NUM_FLOORS-1:0] floor_req_q;
  logic [NUM_FLOORS-1:0] req_in_lift_q;
  logic [NUM_FLOORS-1:0] hall_lamp_c;
  logic [NUM_FLOORS-1:0] cab_lamp_c;

  call_state_t hall_st [NUM_FLOORS];
  call_state_t cab_st  [NUM_FLOORS];

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_hall (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.hall_btn[f]),
      .accept(hall_acc[f])
    );
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cab (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.cab_btn[f]),
      .accept(cab_acc[f])
    );
  end

  // Floor codes above the top floor match no bit.
  always_comb begin
    served = '0;
    for (int f = 0; f < NUM_FLOORS; f++)
      served[f] = (bus.motor_signal == MOTOR_IDLE) &&
                  (bus.lift_floor == FLOOR_W'(f));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      floor_req_q   <= '0;
      req_in_lift_q <= '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
        hall_st[f] <= IDLE;
        cab_st[f]  <= IDLE;
      end
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        floor_req_q[f]   <= hall_acc[f] && !served[f] &&
                            (hall_st[f] == IDLE);
        req_in_lift_q[f] <= cab_acc[f] && !served[f] &&
                            (cab_st[f] == IDLE);
        hall_st[f] <= call_next(hall_st[f], hall_acc[f],
                                served[f]);
        cab_st[f]  <= call_next(cab_st[f], cab_acc[f],
                                served[f]);
      end
    end
  end

  always_comb begin
    hall_lamp_c = '0;
    cab_lamp_c  = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      hall_lamp_c[f] = (hall_st[f] == PENDING);
      cab_lamp_c[f]  = (cab_st[f] == PENDING);
    end
  end

  assign bus.floor_req   = floor_req_q;
  assign bus.req_in_lift = req_in_lift_q;
  assign bus.hall_lamp   = hall_lamp_c;
  assign bus.cab_lamp    = cab_lamp_c;

endmodule

// File: doc/call_request_unit.md
# call_request_unit

Front-end request stage for the elevator car controller: synchronizes and debounces the raw hall-call and in-car (cab) push-buttons, latches each accepted press as a pending call with a lamp, and issues one-cycle request pulses on 11-bit one-hot-per-floor vectors. Those vectors drive the car controller's `floorReq` and `req_in_lift` inputs. The block watches the car controller's floor/motor outputs to retire pending calls when the car stops at the floor.

## Interface
- `NUM_FLOORS`, 11 — floors 0..10; one bit per floor in every vector.
- `DEBOUNCE_CYCLES`, 4 — consecutive synchronized-high cycles required to accept a press; legal range 1..15.
- `clk`  in  1  — clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `hall_btn`  in  11  — raw asynchronous hall-call buttons; bit f is floor f.
- `cab_btn`  in  11  — raw asynchronous in-car floor buttons.
- `lift_floor`  in  4  — current floor reported by the car controller (`liftState`).
- `motor_signal`  in  2  — car motor state: 00 idle, 11 up, 10 down; 01 is treated as moving.
- `floor_req`  out  11  — registered one-cycle request pulses to the car controller's `floorReq`.
- `req_in_lift`  out  11  — registered one-cycle request pulses to the car controller's `req_in_lift`.
- `hall_lamp`  out  11  — pending hall calls.
- `cab_lamp`  out  11  — pending cab calls.

## Operation
- **Per button bit (22 total), input path:**
  - 2-flop synchronizer.
  - Saturating debounce counter `cnt`, width 4.
  - If the synchronized value is 0: `cnt` <= 0.
  - Else if `cnt < DEBOUNCE_CYCLES`: `cnt` increments.
  - Press **accept** event: the synchronized value is 1 and `cnt == DEBOUNCE_CYCLES-1`. This occurs exactly once per hold.
  - Re-arm requires at least one synchronized-low cycle.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces nothing.
- **`served[f]`** = (`motor_signal == 2'b00`) && (`lift_floor == f`). Values of `lift_floor` above 10 serve nothing.
- **Per-floor call FSM (separate for hall and cab), states IDLE / PENDING:**
  - IDLE -> PENDING on accept && !`served[f]`; the same edge sets the lamp and drives a pulse on the matching output bit for exactly one cycle.
  - IDLE + accept && `served[f]`: call satisfied immediately; no lamp, no pulse.
  - PENDING + accept: ignored; no repeat pulse (the car controller holds its own request).
  - PENDING -> IDLE when `served[f]`; the lamp clears.
  - `served[f]` outranks accept on the same edge.
- Hall and cab calls for the same floor are independent; both retire on the same `served` event.
- Any number of floors may accept on the same edge; all corresponding pulse bits assert together.
- Lamps equal the PENDING state; pulse outputs are otherwise 0.

## Timing
- **Reset:** all synchronizer flops, counters and FSMs to 0/IDLE. `floor_req`, `req_in_lift`, `hall_lamp` and `cab_lamp` are all 0 while `rst` is high and after release.
- **Latency:** raw input high before edge k and held -> synchronizer output high after edge k+1 -> accept at edge k+1+`DEBOUNCE_CYCLES`. Pulse and lamp are visible in the cycle after that edge (k+5 with the default).
- **Pulse width:** exactly one clock.
- **Retire latency:** the lamp drops on the first edge at which `served[f]` is sampled true.
- **Reset mid-operation:** pending calls are lost; the buttons must be re-pressed after reset, and a still-held button re-accepts after the full debounce.
- No backpressure: the car controller samples its request inputs every cycle.

## Structure
- Package `lift_pkg`:
  - `NUM_FLOORS = 11`, `FLOOR_W = 4`.
  - `MOTOR_IDLE = 2'b00`, `MOTOR_UP = 2'b11`, `MOTOR_DOWN = 2'b10`.
  - Call-state enum `call_state_t` {IDLE, PENDING}.
  - Shared with the car controller and with any later door/indicator stage.
- Sub-module `btn_debounce`: synchronizer, counter and single-cycle accept output; parameter `DEBOUNCE_CYCLES`. Instantiated 22 times by generate.
- Top level: 22 call FSMs, `served` decode and output registers.

## Test plan
- **Single hall press:** `lift_floor`=0, motor 00; `hall_btn[5]` held 10 cycles -> `floor_req` == 11'h020 for exactly one cycle, 6 cycles after the press edge; `hall_lamp[5]`=1.
- **Glitch:** `cab_btn[3]` high for 3 cycles -> no pulse and `cab_lamp` stays 0. A second 4-cycle hold -> `req_in_lift` == 11'h008 for one cycle.
- **Retire:** with `hall_lamp[5]`=1, drive `lift_floor`=5 with motor 11 -> the lamp stays set; then drive motor 00 -> `hall_lamp[5]` clears next edge.
- **Served on press:** `lift_floor`=2, motor 00, `hall_btn[2]` pressed -> no pulse, no lamp.
- **Simultaneous and repeated presses:**
  - `cab_btn[1]`, `cab_btn[7]` and `cab_btn[10]` pressed on the same edge, motor 11 -> one `req_in_lift` pulse == 11'h482.
  - Re-pressing `cab_btn[7]` while it is pending -> no further pulse.
- **Reset mid-operation:** assert `rst` asynchronously with lamps 11'h0A0 set -> all outputs 0 immediately. A held button re-accepts `DEBOUNCE_CYCLES`+2 cycles after `rst` is released.
